im_loadable: RTL and testbench
==============================

Name: im_loadable

Overview:
- Parametrised successor to the fixed-size fetch ROM: synchronous-read instruction memory with a runtime program-load port.
- Fetch side feeds the IF stage, with stall hold, a valid flag and misalignment detection.
- Load side takes a byte stream (debug UART / boot loader) over a valid/ready handshake, assembles big-endian words and writes them from a chosen base word index.
- Fetch is blocked while a load is in progress.

Parameters:
- IM_DEPTH, 2048, number of words (power of two).
- DATA_W, 32, instruction width (multiple of 8).
- ADDR_W, 32, fetch byte-address width.
- BYTE_REVERSE, 0, when 1, bit-reverse each word on read (legacy encoding).
- INIT_FILE, "", hex image loaded with $readmemh at elaboration if non-empty.

Ports:
- cpu_clk_50M  in  1  clock.
- cpu_rst_n  in  1  asynchronous active-low reset.
- imce  in  1  fetch enable.
- imaddr  in  ADDR_W  fetch byte address.
- stall  in  1  hold the fetch output.
- inst  out  DATA_W  fetched instruction.
- inst_valid  out  1  inst is a fresh fetch.
- misalign  out  1  imaddr[1:0] was non-zero for the current inst.
- ld_start  in  1  start-load pulse.
- ld_base  in  $clog2(IM_DEPTH)  first word index to write.
- ld_words  in  $clog2(IM_DEPTH)+1  number of words to load.
- ld_byte  in  8  load data byte.
- ld_valid  in  1  ld_byte valid.
- ld_ready  out  1  loader accepts a byte.
- ld_busy  out  1  loader not idle.
- ld_done  out  1  one-cycle pulse at load completion.

Behaviour:
- Reset (async, cpu_rst_n=0):
  - inst=0, inst_valid=0, misalign=0, ld_ready=0, ld_busy=0, ld_done=0.
  - Loader state = IDLE; byte counter, word counter and assembly register cleared.
  - Memory contents are not cleared.
- Fetch, 1-cycle latency; the condition is evaluated at each posedge:
  - stall=1: inst, inst_valid and misalign hold. Stall has priority over everything.
  - Else if ld_busy=1: inst_valid<=0 and inst holds.
  - Else if imce=1:
    - word index = imaddr[$clog2(IM_DEPTH)+1:2]. Upper bits are ignored, so the address wraps modulo IM_DEPTH.
    - inst<=mem[index], bit-reversed if BYTE_REVERSE=1.
    - inst_valid<=1.
    - misalign<=(imaddr[1:0]!=0). If misaligned, inst<=0 instead of the memory word.
  - Else (imce=0): inst_valid<=0 and inst holds.
- Loader FSM, states IDLE, LOAD, WRITE, DONE:
  - IDLE: ld_ready=0, ld_busy=0.
    - ld_start=1 and ld_words!=0: latch ld_base as waddr and ld_words as wcnt, clear the byte counter, go to LOAD.
    - ld_start=1 and ld_words==0: go directly to DONE, no write.
  - LOAD: ld_ready=1, ld_busy=1.
    - Each cycle with ld_valid&ld_ready accepts one byte: asm<={asm[DATA_W-9:0], ld_byte}, so the first byte becomes the MSB.
    - The byte counter increments; acceptance of the (DATA_W/8)-th byte moves the FSM to WRITE.
  - WRITE (1 cycle): ld_ready=0.
    - mem[waddr]<=asm (stored unreversed).
    - waddr<=waddr+1, wrapping modulo IM_DEPTH.
    - wcnt<=wcnt-1, byte counter cleared.
    - Go to DONE if wcnt==1, else back to LOAD.
  - DONE (1 cycle): ld_done=1, ld_busy=1, then go to IDLE.
- ld_start outside IDLE is ignored.
- Reset mid-load aborts the load: words already written stay in memory, the partial word is discarded.
- A fetch at the same index as the WRITE cycle cannot occur, because fetch is blocked while busy.
- First fetch after a load returns the newly written data.

Decomposition:
- mips_cpu_pkg gains:
  - IM_DEPTH default.
  - im_widx_t (word-index type).
  - ld_state_t enum {LD_IDLE, LD_LOAD, LD_WRITE, LD_DONE}.
  - reverse() function, shared.
- One sub-module, im_byte_loader: the FSM, byte assembly and counters. It outputs we, waddr, wdata, busy, done.
- The memory array and fetch path stay in the top module.

Test Plan:
- Reset mid-fetch: assert cpu_rst_n=0 while inst_valid=1 -> inst=0, inst_valid=0 immediately (async).
- Load 2 words at base 4: bytes 20 08 00 7F 21 EF 00 7F, ld_valid held high -> ld_done pulses once after the 10th busy cycle (2×4 LOAD + 2 WRITE); fetch imaddr 0x10 -> inst=0x2008007F; fetch 0x14 -> 0x21EF007F.
- Backpressure: gap ld_valid low for 3 cycles mid-word -> no byte lost, same memory result; ld_ready=0 during WRITE.
- Fetch while busy: imce=1 during LOAD -> inst_valid=0 and inst unchanged; fetch resumes the cycle after DONE.
- Stall/misalign: fetch 0x10, then stall=1 for 2 cycles with imaddr changed -> inst stays 0x2008007F; fetch 0x12 -> misalign=1, inst=0.
- Edge cases:
  - ld_words=0 -> ld_done the next cycle, memory unchanged.
  - Load 2 words at base IM_DEPTH-1 -> second word wraps to index 0.
  - Reset after 6 bytes -> index base holds the word, base+1 unchanged.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types and helpers for the instruction-memory slice of the MIPS core.
package mips_cpu_pkg;

  // Default instruction-memory depth in words.
  localparam int IM_DEPTH_DEFAULT = 2048;
  localparam int IM_WIDX_W        = $clog2(IM_DEPTH_DEFAULT);

  // Widest word the reverse() helper handles.
  localparam int IM_MAX_W = 128;

  // Word index into the default-sized instruction memory.
  typedef logic [IM_WIDX_W-1:0] im_widx_t;

  // Program-loader states.
  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_t;

  // Bit-reverse the low 'width' bits of w (legacy instruction encoding).
  function automatic logic [IM_MAX_W-1:0] reverse(input logic [IM_MAX_W-1:0] w,
                                                  input int width);
    logic [IM_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < IM_MAX_W; i++) begin
      if (i < width) begin
        r[i] = w[width-1-i];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/im_byte_loader.sv
// Byte-stream program loader: assembles big-endian words and emits one
// memory write per word, starting at a base index and wrapping at the top.
module im_byte_loader
  import mips_cpu_pkg::*;
#(
  parameter int IM_DEPTH = IM_DEPTH_DEFAULT,
  parameter int DATA_W   = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [$clog2(IM_DEPTH)-1:0] base_i,
  input  logic [$clog2(IM_DEPTH):0]   words_i,
  input  logic [7:0]                  byte_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        we_o,
  output logic [$clog2(IM_DEPTH)-1:0] waddr_o,
  output logic [DATA_W-1:0]           wdata_o
);

  localparam int AW    = $clog2(IM_DEPTH);
  localparam int BYTES = DATA_W / 8;
  localparam int BCW   = $clog2(BYTES) + 1;

  localparam logic [BCW-1:0] BCNT_LAST = BCW'(BYTES - 1);
  localparam logic [AW:0]    WCNT_ONE  = {{AW{1'b0}}, 1'b1};

  ld_state_t          state_q, state_d;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [AW:0]        wcnt_q,  wcnt_d;
  logic [BCW-1:0]     bcnt_q,  bcnt_d;
  logic [DATA_W-1:0]  asm_q,   asm_d;

  // State and datapath registers; reset returns to idle with counters cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LD_IDLE;
      waddr_q <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
    end
  end

  // Next-state and counter logic: accept bytes in LOAD, commit a word in WRITE.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    case (state_q)
      LD_IDLE: begin
        if (start_i) begin
          if (words_i != '0) begin
            waddr_d = base_i;
            wcnt_d  = words_i;
            bcnt_d  = '0;
            state_d = LD_LOAD;
          end else begin
            state_d = LD_DONE;
          end
        end else begin
          state_d = LD_IDLE;
        end
      end
      LD_LOAD: begin
        if (valid_i) begin
          // First byte of a word ends up in the MSB.
          asm_d  = (asm_q << 4'd8) | DATA_W'(byte_i);
          bcnt_d = bcnt_q + BCW'(1);
          if (bcnt_q == BCNT_LAST) begin
            state_d = LD_WRITE;
          end else begin
            state_d = LD_LOAD;
          end
        end else begin
          state_d = LD_LOAD;
        end
      end
      LD_WRITE: begin
        waddr_d = waddr_q + AW'(1);
        wcnt_d  = wcnt_q - (AW+1)'(1);
        bcnt_d  = '0;
        if (wcnt_q == WCNT_ONE) begin
          state_d = LD_DONE;
        end else begin
          state_d = LD_LOAD;
        end
      end
      LD_DONE: begin
        state_d = LD_IDLE;
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    we_o    = 1'b0;
    case (state_q)
      LD_IDLE: begin
        busy_o = 1'b0;
      end
      LD_LOAD: begin
        ready_o = 1'b1;
        busy_o  = 1'b1;
      end
      LD_WRITE: begin
        busy_o = 1'b1;
        we_o   = 1'b1;
      end
      LD_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign waddr_o = waddr_q;
  assign wdata_o = asm_q;

endmodule

// File: rtl/im_loadable.sv
// Synchronous-read instruction memory with a runtime byte-stream load port.
// Fetch is held off while the loader is busy.
module im_loadable
  import mips_cpu_pkg::*;
#(
  parameter int    IM_DEPTH     = IM_DEPTH_DEFAULT,
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 32,
  parameter bit    BYTE_REVERSE = 1'b0,
  parameter string INIT_FILE    = ""
) (
  input  logic                        cpu_clk_50M,
  input  logic                        cpu_rst_n,
  input  logic                        imce,
  input  logic [ADDR_W-1:0]           imaddr,
  input  logic                        stall,
  output logic [DATA_W-1:0]           inst,
  output logic                        inst_valid,
  output logic                        misalign,
  input  logic                        ld_start,
  input  logic [$clog2(IM_DEPTH)-1:0] ld_base,
  input  logic [$clog2(IM_DEPTH):0]   ld_words,
  input  logic [7:0]                  ld_byte,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  output logic                        ld_busy,
  output logic                        ld_done
);

  localparam int AW = $clog2(IM_DEPTH);

  logic [DATA_W-1:0] mem_q [IM_DEPTH];

  logic              ld_we_s;
  logic [AW-1:0]     ld_waddr_s;
  logic [DATA_W-1:0] ld_wdata_s;
  logic              ld_busy_s;

  logic [AW-1:0]     fetch_idx_s;
  logic              fetch_mis_s;
  logic [DATA_W-1:0] rd_word_s;

  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;

  if (ADDR_W > AW + 2) begin : g_addr_hi
    // Upper address bits are deliberately ignored so fetch wraps modulo depth.
    logic addr_hi_unused_s;
    assign addr_hi_unused_s = ^imaddr[ADDR_W-1:AW+2];
  end

  im_byte_loader #(
    .IM_DEPTH (IM_DEPTH),
    .DATA_W   (DATA_W)
  ) u_loader (
    .clk_i   (cpu_clk_50M),
    .rst_ni  (cpu_rst_n),
    .start_i (ld_start),
    .base_i  (ld_base),
    .words_i (ld_words),
    .byte_i  (ld_byte),
    .valid_i (ld_valid),
    .ready_o (ld_ready),
    .busy_o  (ld_busy_s),
    .done_o  (ld_done),
    .we_o    (ld_we_s),
    .waddr_o (ld_waddr_s),
    .wdata_o (ld_wdata_s)
  );

  assign ld_busy     = ld_busy_s;
  assign fetch_idx_s = imaddr[AW+1:2];
  assign fetch_mis_s = (imaddr[1:0] != 2'b00);

  // Memory write port; contents survive reset.
  always_ff @(posedge cpu_clk_50M) begin
    if (ld_we_s) begin
      mem_q[ld_waddr_s] <= ld_wdata_s;
    end
  end

  // Read word selection, with optional legacy bit reversal.
  always_comb begin
    if (BYTE_REVERSE) begin
      rd_word_s = DATA_W'(reverse(IM_MAX_W'(mem_q[fetch_idx_s]), DATA_W));
    end else begin
      rd_word_s = mem_q[fetch_idx_s];
    end
  end

  // Fetch next state: stall holds everything, a busy loader blocks fetch.
  always_comb begin
    inst_d  = inst_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    if (stall) begin
      valid_d = valid_q;
    end else if (ld_busy_s) begin
      valid_d = 1'b0;
    end else if (imce) begin
      valid_d = 1'b1;
      mis_d   = fetch_mis_s;
      if (fetch_mis_s) begin
        inst_d = '0;
      end else begin
        inst_d = rd_word_s;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Fetch output registers.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      inst_q  <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign misalign   = mis_q;

endmodule

// File: tb/tb_im_loadable.sv
// Self-checking bench for im_loadable: directed table, multi-cycle load
// sequences and a randomized phase against an associative-array memory model.
module tb_im_loadable;

  localparam int D = 2048;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n   = 1'b0;
  logic        imce        = 1'b0;
  logic [31:0] imaddr      = 32'h0;
  logic        stall       = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        misalign;
  logic        ld_start    = 1'b0;
  logic [10:0] ld_base     = 11'h0;
  logic [11:0] ld_words    = 12'h0;
  logic [7:0]  ld_byte     = 8'h0;
  logic        ld_valid    = 1'b0;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;

  int checks = 0;
  int errors = 0;

  // Reference memory: word index -> contents, only for words the bench wrote.
  logic [31:0] mm [int];

  typedef struct {
    logic [31:0] addr;
    logic        stall;
    logic        imce;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_mis;
  } vec_t;

  vec_t tbl [11];

  im_loadable dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .imce        (imce),
    .imaddr      (imaddr),
    .stall       (stall),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .misalign    (misalign),
    .ld_start    (ld_start),
    .ld_base     (ld_base),
    .ld_words    (ld_words),
    .ld_byte     (ld_byte),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_busy     (ld_busy),
    .ld_done     (ld_done)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge cpu_clk_50M);
  endtask

  // Big-endian word k of a byte queue, built arithmetically.
  function automatic logic [31:0] word_of(input logic [7:0] q[$], input int k);
    logic [31:0] w;
    w = 32'h0;
    for (int j = 0; j < 4; j++) w = w * 32'd256 + 32'(q[4*k+j]);
    return w;
  endfunction

  task automatic fetch_chk(input string nm, input logic [31:0] addr);
    int idx;
    logic mis;
    imce   = 1'b1;
    stall  = 1'b0;
    imaddr = addr;
    step();
    imce = 1'b0;
    idx  = int'((addr >> 2) % 32'(D));
    mis  = (addr[1:0] != 2'b00);
    chk({nm, "_valid"}, {31'h0, inst_valid}, 32'h1);
    chk({nm, "_mis"}, {31'h0, misalign}, {31'h0, mis});
    if (mis) chk({nm, "_inst"}, inst, 32'h0);
    else if (mm.exists(idx)) chk({nm, "_inst"}, inst, mm[idx]);
  endtask

  // Run one load; optional 3-cycle ld_valid gap before byte gap_at; optional
  // check that a concurrent fetch is blocked and inst holds hold_exp.
  task automatic do_load(input string nm, input int base, input int n,
                         input logic [7:0] bq[$], input int gap_at, input bit fchk,
                         input logic [31:0] hold_exp, output int busy_n, output int wr_n);
    int bi;
    int gl;
    bit seen;
    bi = 0; gl = 3; seen = 1'b0; busy_n = 0; wr_n = 0;
    ld_base  = 11'(base);
    ld_words = 12'(n);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (bi == gap_at && gl > 0) begin
        ld_valid = 1'b0;
        gl--;
      end else if (bi < bq.size()) begin
        ld_valid = 1'b1;
        ld_byte  = bq[bi];
      end else begin
        ld_valid = 1'b0;
      end
      if (fchk && c >= 1) begin
        chk({nm, "_blk_valid"}, {31'h0, inst_valid}, 32'h0);
        chk({nm, "_blk_inst"}, inst, hold_exp);
      end
      if (ld_done) begin
        seen = 1'b1;
        break;
      end
      if (ld_busy) busy_n++;
      if (ld_busy && !ld_ready) wr_n++;
      if (ld_valid && ld_ready) bi++;
      step();
    end
    ld_valid = 1'b0;
    chk({nm, "_done_seen"}, {31'h0, seen}, 32'h1);
    step();
    chk({nm, "_done_pulse"}, {31'h0, ld_done}, 32'h0);
    chk({nm, "_idle"}, {31'h0, ld_busy}, 32'h0);
    if (fchk) chk({nm, "_blk_done"}, {31'h0, inst_valid}, 32'h0);
    for (int k = 0; k < n; k++) mm[(base + k) % D] = word_of(bq, k);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] qe[$];
    int bn, wn, bi, cnt;

    // Reset state
    cpu_rst_n = 1'b0;
    step(); step();
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_mis", {31'h0, misalign}, 32'h0);
    chk("rst_ready", {31'h0, ld_ready}, 32'h0);
    chk("rst_busy", {31'h0, ld_busy}, 32'h0);
    chk("rst_done", {31'h0, ld_done}, 32'h0);
    cpu_rst_n = 1'b1;
    step();

    // Two words at base 4, ld_valid held high
    q = '{8'h20, 8'h08, 8'h00, 8'h7F, 8'h21, 8'hEF, 8'h00, 8'h7F};
    do_load("ld2", 4, 2, q, -1, 1'b0, 32'h0, bn, wn);
    chk("ld2_busy_cycles", 32'(bn), 32'd10);
    chk("ld2_write_cycles", 32'(wn), 32'd2);

    // Directed fetch table: stall hold, misalign, imce=0 hold, wrap of upper bits
    tbl[0]  = '{32'h0000_0010, 1'b0, 1'b1, 32'h2008_007F, 1'b1, 1'b0};
    tbl[1]  = '{32'h0000_0014, 1'b1, 1'b1, 32'h2008_007F, 1'b1, 1'b0};
    tbl[2]  = '{32'h0000_0018, 1'b1, 1'b0, 32'h2008_007F, 1'b1, 1'b0};
    tbl[3]  = '{32'h0000_0014, 1'b0, 1'b1, 32'h21EF_007F, 1'b1, 1'b0};
    tbl[4]  = '{32'h0000_0012, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
    tbl[5]  = '{32'h0000_0010, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    tbl[6]  = '{32'h0000_2010, 1'b0, 1'b1, 32'h2008_007F, 1'b1, 1'b0};
    tbl[7]  = '{32'hFFFF_0014, 1'b0, 1'b1, 32'h21EF_007F, 1'b1, 1'b0};
    tbl[8]  = '{32'h0000_0011, 1'b1, 1'b1, 32'h21EF_007F, 1'b1, 1'b0};
    tbl[9]  = '{32'h0000_0013, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
    tbl[10] = '{32'h0000_0010, 1'b0, 1'b1, 32'h2008_007F, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      imaddr = tbl[i].addr;
      stall  = tbl[i].stall;
      imce   = tbl[i].imce;
      step();
      chk($sformatf("tbl%0d_inst", i), inst, tbl[i].e_inst);
      chk($sformatf("tbl%0d_valid", i), {31'h0, inst_valid}, {31'h0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_mis", i), {31'h0, misalign}, {31'h0, tbl[i].e_mis});
    end

    // Asynchronous reset while inst_valid is high
    cpu_rst_n = 1'b0;
    #1;
    chk("rstf_inst", inst, 32'h0);
    chk("rstf_valid", {31'h0, inst_valid}, 32'h0);
    imce = 1'b0;
    stall = 1'b0;
    step();
    cpu_rst_n = 1'b1;
    step();

    // Backpressure: 3-cycle gap after the second byte
    do_load("bp", 8, 2, q, 2, 1'b0, 32'h0, bn, wn);
    chk("bp_busy_cycles", 32'(bn), 32'd13);
    chk("bp_write_cycles", 32'(wn), 32'd2);
    fetch_chk("bp_f0", 32'h20);
    chk("bp_f0_const", inst, 32'h2008_007F);
    fetch_chk("bp_f1", 32'h24);
    chk("bp_f1_const", inst, 32'h21EF_007F);

    // Zero-length load
    qe = {};
    do_load("z", 4, 0, qe, -1, 1'b0, 32'h0, bn, wn);
    chk("z_busy_cycles", 32'(bn), 32'd0);
    fetch_chk("z_f", 32'h10);

    // Wrap of the write index past the top of memory
    q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    do_load("wrap", D - 1, 2, q, -1, 1'b0, 32'h0, bn, wn);
    fetch_chk("wrap_top", 32'h1FFC);
    chk("wrap_top_const", inst, 32'hA1A2_A3A4);
    fetch_chk("wrap_zero", 32'h0);
    chk("wrap_zero_const", inst, 32'hB1B2_B3B4);

    // Fetch requested throughout a load is blocked, then returns new data
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    imce   = 1'b1;
    imaddr = 32'h10;
    do_load("fb", 4, 1, q, -1, 1'b1, mm[4], bn, wn);
    step();
    chk("fb_resume_valid", {31'h0, inst_valid}, 32'h1);
    chk("fb_resume_inst", inst, 32'hDEAD_BEEF);
    imce = 1'b0;
    step();

    // Reset after 6 accepted bytes of a 2-word load at base 3
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    ld_base = 11'd3; ld_words = 12'd2; ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    bi = 0; cnt = 0;
    while (bi < 6 && cnt < 60) begin
      ld_valid = 1'b1;
      ld_byte  = q[bi];
      if (ld_ready) bi++;
      step();
      cnt++;
    end
    chk("abort_bytes", 32'(bi), 32'd6);
    ld_valid  = 1'b0;
    cpu_rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'h0, ld_busy}, 32'h0);
    chk("abort_ready", {31'h0, ld_ready}, 32'h0);
    step();
    cpu_rst_n = 1'b1;
    step();
    mm[3] = word_of(q, 0);
    fetch_chk("abort_w0", 32'hC);
    fetch_chk("abort_w1", 32'h10);
    chk("abort_w1_const", inst, 32'hDEAD_BEEF);

    // Randomized loads and fetches against the model
    for (int it = 0; it < 25; it++) begin
      int n, base, gap, idx;
      logic [31:0] addr;
      n    = $urandom_range(1, 3);
      base = $urandom_range(0, D - 1);
      gap  = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, 3);
      q = {};
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      do_load($sformatf("rnd%0d", it), base, n, q, gap, 1'b0, 32'h0, bn, wn);
      chk($sformatf("rnd%0d_busy", it), 32'(bn), 32'(5 * n + ((gap < 0) ? 0 : 3)));
      for (int f = 0; f < 3; f++) begin
        idx  = (base + $urandom_range(0, n - 1)) % D;
        addr = ($urandom & 32'hFFFF_E000) | (32'(idx) << 2);
        if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
        fetch_chk($sformatf("rnd%0d_f%0d", it, f), addr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
